arm_fetch: RTL

Instruction fetch stage directly upstream of arm_decode. It keeps the fetch PC, issues word requests to instruction memory over a valid/ready handshake, and buffers in-order responses in a small prefetch queue. It presents one instruction at a time, with its address, to the decoder and condition checker. Branch and PC-write redirects from later stages flush the queue and squash any requests still in flight.

---
 rtl/arm_fetch.sv | 127 ++++++++++++
 1 files changed

// File: rtl/arm_fetch.sv
// Instruction fetch stage: fetch PC, valid/ready imem requests, in-order prefetch queue, redirect drain.
// Optional build macro ARM_FETCH_BYPASS_EN forwards a response straight to decode when the queue is empty.
module arm_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          QDEPTH    = 2,
  parameter int          MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc8,
  input  logic        inst_ready
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH) + 2;

  typedef enum logic {RUN, DRAIN} state_t;

  state_t        state, state_n;
  logic [31:0]   fetch_pc;
  logic [31:0]   q_data [QDEPTH];
  logic [31:0]   q_pc   [QDEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] qcount, outst, drop_cnt, drop_n;
  logic          req_fire, resp_ok, dropping, head_valid, byp, push, qpop;
  logic [31:0]   resp_pc;
  logic          unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // A response with nothing in flight is a leftover from before reset and is ignored.
  assign resp_ok    = imem_resp_valid && (outst != '0);
  assign dropping   = (drop_cnt != '0);
  assign head_valid = (qcount != '0);
  assign resp_pc    = fetch_pc - (32'(outst) << 2);

  assign imem_req_valid = !rst && (state == RUN) && !redirect &&
                          ((outst + qcount) < CW'(QDEPTH)) && (outst < CW'(MAX_OUTST));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

`ifdef ARM_FETCH_BYPASS_EN
  assign byp = !rst && !head_valid && resp_ok && !dropping && !redirect;
`else
  assign byp = 1'b0;
`endif

  assign push       = resp_ok && !dropping && !redirect && !(byp && inst_ready);
  assign qpop       = head_valid && inst_ready && !redirect;
  assign inst_valid = !rst && (head_valid || byp);
  assign inst_pc8   = inst_pc + 32'd8;

  always_comb begin
    inst    = '0;
    inst_pc = '0;
    if (!rst && head_valid) begin
      inst    = q_data[head];
      inst_pc = q_pc[head];
    end else if (byp) begin
      inst    = imem_resp_data;
      inst_pc = resp_pc;
    end
  end

  // Stale responses still in flight at a redirect must be discarded before fetching resumes.
  always_comb begin
    drop_n = drop_cnt;
    if (redirect)
      drop_n = outst - CW'(resp_ok);
    else if (resp_ok && dropping)
      drop_n = drop_cnt - CW'(1);
    state_n = (drop_n != '0) ? DRAIN : RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      qcount   <= '0;
      outst    <= '0;
      drop_cnt <= '0;
    end else begin
      outst    <= outst + CW'(req_fire) - CW'(resp_ok);
      drop_cnt <= drop_n;
      if (redirect) begin
        fetch_pc <= {redirect_pc[31:2], 2'b00};
        head     <= '0;
        tail     <= '0;
        qcount   <= '0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (push)     tail     <= tail + PW'(1);
        if (qpop)     head     <= head + PW'(1);
        qcount <= qcount + CW'(push) - CW'(qpop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_data[tail] <= imem_resp_data;
      q_pc[tail]   <= resp_pc;
    end
  end

  // Request throttling reserves a slot per request, so a push into a full queue is a design bug.
  always @(posedge clk) begin
    if (!rst && push) assert (qcount != CW'(QDEPTH));
  end

endmodule
